rv_plic_src_filter: RTL

Conditioning stage directly upstream of the PLIC gateway; its output drives the PLIC intr_src_i bus. For each raw interrupt line it provides:
- a multi-flop synchronizer for asynchronous peripherals;
- a per-source debounce filter, with a per-source bypass;
- a saturating count of rejected glitches, for software diagnostics.

---
 rtl/rv_plic_src_filter.sv | 114 +++++++++++
 1 files changed

// File: rtl/rv_plic_src_filter.sv
// rv_plic_src_filter: per-source synchronizer + debounce filter feeding the
// PLIC gateway, with an optional saturating glitch counter for diagnostics.
// Optional feature macro: RV_PLIC_SRC_FILTER_GLITCH_CNT_EN (glitch counter).
// Source 0 is reserved by the PLIC and has no logic behind it.

// Single-source lane: sync chain, debounce counter, registered output.
module rv_plic_src_filter_lane #(
  parameter int SyncStages = 2,
  parameter int FiltCycles = 4,
  parameter int CntW       = $clog2(FiltCycles+1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic en_i,
  output logic out_o,
  output logic glitch_o
);
  logic [SyncStages-1:0] r_sync;
  logic [CntW-1:0]       r_cnt;
  logic                  r_out;
  logic                  w_sync;
  logic                  w_mism;

  assign w_sync = r_sync[SyncStages-1];
  assign w_mism = w_sync ^ r_out;
  assign out_o  = r_out;

  // Shift the raw line through the synchronizer chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sync <= '0;
    else         r_sync <= {r_sync[SyncStages-2:0], raw_i};
  end

  // Debounce: follow the input only after FiltCycles consecutive mismatches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out <= 1'b0;
      r_cnt <= '0;
    end else if (!en_i) begin
      r_out <= w_sync;
      r_cnt <= '0;
    end else if (w_mism) begin
      if (r_cnt == CntW'(FiltCycles-1)) begin
        r_out <= w_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

`ifdef RV_PLIC_SRC_FILTER_GLITCH_CNT_EN
  // A partial count abandoned because the input returned is a rejected glitch.
  assign glitch_o = en_i & ~w_mism & (r_cnt != '0);
`else
  assign glitch_o = 1'b0;
`endif
endmodule

module rv_plic_src_filter #(
  parameter int NumSrc     = 32,
  parameter int SyncStages = 2,
  parameter int FiltCycles = 4,
  parameter int CntW       = $clog2(FiltCycles+1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] intr_raw_i,
  input  logic [NumSrc-1:0] filt_en_i,
  input  logic              glitch_clr_i,
  output logic [NumSrc-1:0] intr_src_o,
  output logic [15:0]       glitch_cnt_o
);
  logic [NumSrc-1:0] w_glitch;

  assign intr_src_o[0] = 1'b0;
  assign w_glitch[0]   = 1'b0;

  for (genvar s = 1; s < NumSrc; s++) begin : g_src
    rv_plic_src_filter_lane #(
      .SyncStages (SyncStages),
      .FiltCycles (FiltCycles),
      .CntW       (CntW)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .raw_i    (intr_raw_i[s]),
      .en_i     (filt_en_i[s]),
      .out_o    (intr_src_o[s]),
      .glitch_o (w_glitch[s])
    );
  end

`ifdef RV_PLIC_SRC_FILTER_GLITCH_CNT_EN
  logic [15:0] r_gcnt;
  logic        w_unused;
  assign w_unused     = ^{intr_raw_i[0], filt_en_i[0]};
  assign glitch_cnt_o = r_gcnt;

  // Saturating count of cycles with any glitch; clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                               r_gcnt <= '0;
    else if (glitch_clr_i)                     r_gcnt <= '0;
    else if (|w_glitch && r_gcnt != 16'hFFFF)  r_gcnt <= r_gcnt + 16'd1;
  end
`else
  logic w_unused;
  assign w_unused     = ^{intr_raw_i[0], filt_en_i[0], glitch_clr_i, w_glitch};
  assign glitch_cnt_o = 16'h0;
`endif
endmodule
